// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-requester BRAM port arbiter.
// Stats counters are only built when BRAM_ARB_STATS_EN is defined.
package bram_arb_pkg;

   localparam int AW_DEF     = 13;
   localparam int DW_DEF     = 32;
   localparam int BEW_DEF    = DW_DEF / 8;
   localparam int RD_LAT_MAX = 4;
   localparam int STAT_W     = 16;

   typedef logic req_id_t;

   typedef struct packed {
      logic                we;
      logic [AW_DEF-1:0]   addr;
      logic [DW_DEF-1:0]   wdata;
      logic [BEW_DEF-1:0]  be;
   } bram_cmd_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// Read-tag delay line: one tag per issued command, head emerges DEPTH cycles later.
module bram_arb_tag_pipe
   import bram_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk25,
   input  logic    fpga_rst_n,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t pipe_q [DEPTH];

   always_ff @(posedge clk25 or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         // NOTE: every stage is cleared, not just the head, so reads in flight at reset never return.
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let each stage take its predecessor's old value.
         pipe_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one registered BRAM port between two requesters.
// Optional grant/conflict counters: define BRAM_ARB_STATS_EN.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int BEW    = BEW_DEF,
   parameter int RD_LAT = 2
) (
   input  logic            clk25,
   input  logic            fpga_rst_n,

   input  logic            r0_req,
   input  logic            r0_we,
   input  logic [AW-1:0]   r0_addr,
   input  logic [DW-1:0]   r0_wdata,
   input  logic [BEW-1:0]  r0_be,
   output logic            r0_gnt,
   output logic            r0_rvalid,
   output logic [DW-1:0]   r0_rdata,

   input  logic            r1_req,
   input  logic            r1_we,
   input  logic [AW-1:0]   r1_addr,
   input  logic [DW-1:0]   r1_wdata,
   input  logic [BEW-1:0]  r1_be,
   output logic            r1_gnt,
   output logic            r1_rvalid,
   output logic [DW-1:0]   r1_rdata,

   output logic            bram_ce,
   output logic            bram_we,
   output logic [AW-1:0]   bram_addr,
   output logic [DW-1:0]   bram_wdata,
   output logic [BEW-1:0]  bram_webyte,
   input  logic [DW-1:0]   bram_rdata
`ifdef BRAM_ARB_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_gnt0,
   output logic [STAT_W-1:0] stat_gnt1,
   output logic [STAT_W-1:0] stat_conflict
`endif
);

   if (AW != AW_DEF || DW != DW_DEF || BEW != BEW_DEF) begin : g_bad_width
      $error("bram_port_arbiter: widths must match bram_arb_pkg defaults");
   end
   if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("bram_port_arbiter: RD_LAT must be 1..RD_LAT_MAX");
   end

   req_id_t         prio_q, prio_d;
   req_id_t         win_id;
   logic            any_gnt;
   bram_cmd_t       cmd_d;
   rd_tag_t         tag_push, tag_head;

   logic            ce_q, we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [BEW-1:0]  webyte_q;
   logic            rvalid0_q, rvalid1_q;

   always_comb begin
      // NOTE: defaults first, so no branch leaves a signal unassigned and infers a latch.
      r0_gnt   = 1'b0;
      r1_gnt   = 1'b0;
      win_id   = 1'b0;
      prio_d   = prio_q;
      if (r0_req && (!r1_req || prio_q == 1'b0)) begin
         r0_gnt = 1'b1;
         win_id = 1'b0;
      end else if (r1_req) begin
         r1_gnt = 1'b1;
         win_id = 1'b1;
      end
      any_gnt = r0_gnt | r1_gnt;
      // The loser gets priority next time, giving strict alternation under contention.
      if (any_gnt) prio_d = ~win_id;
      cmd_d = win_id ? '{we: r1_we, addr: r1_addr, wdata: r1_wdata, be: r1_be}
                     : '{we: r0_we, addr: r0_addr, wdata: r0_wdata, be: r0_be};
      tag_push = '{valid: any_gnt && !cmd_d.we, id: win_id};
   end

   always_ff @(posedge clk25 or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         prio_q    <= 1'b0;
         ce_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         webyte_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         prio_q   <= prio_d;
         ce_q     <= any_gnt;
         we_q     <= any_gnt && cmd_d.we;
         webyte_q <= (any_gnt && cmd_d.we) ? cmd_d.be : '0;
         // Address and data hold their last value on idle cycles.
         if (any_gnt) begin
            addr_q  <= cmd_d.addr;
            wdata_q <= cmd_d.wdata;
         end
         rvalid0_q <= tag_head.valid && (tag_head.id == 1'b0);
         rvalid1_q <= tag_head.valid && (tag_head.id == 1'b1);
      end
   end

   // The tag head lines up one cycle before data; the rvalid flop absorbs the command register stage.
   bram_arb_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk25      (clk25),
      .fpga_rst_n (fpga_rst_n),
      .tag_i      (tag_push),
      .tag_o      (tag_head)
   );

   assign bram_ce     = ce_q;
   assign bram_we     = we_q;
   assign bram_addr   = addr_q;
   assign bram_wdata  = wdata_q;
   assign bram_webyte = webyte_q;
   assign r0_rvalid   = rvalid0_q;
   assign r1_rvalid   = rvalid1_q;
   assign r0_rdata    = bram_rdata;
   assign r1_rdata    = bram_rdata;

`ifdef BRAM_ARB_STATS_EN
   logic [STAT_W-1:0] gnt0_cnt_q, gnt1_cnt_q, conflict_cnt_q;

   always_ff @(posedge clk25 or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         gnt0_cnt_q     <= '0;
         gnt1_cnt_q     <= '0;
         conflict_cnt_q <= '0;
      end else if (stat_clr) begin
         gnt0_cnt_q     <= '0;
         gnt1_cnt_q     <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if (r0_gnt)           gnt0_cnt_q     <= sat_inc(gnt0_cnt_q);
         if (r1_gnt)           gnt1_cnt_q     <= sat_inc(gnt1_cnt_q);
         if (r0_req && r1_req) conflict_cnt_q <= sat_inc(conflict_cnt_q);
      end
   end

   assign stat_gnt0     = gnt0_cnt_q;
   assign stat_gnt1     = gnt1_cnt_q;
   assign stat_conflict = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter with a behavioural 2-cycle-latency byte-writable BRAM.
// Counter checks are compiled in when BRAM_ARB_STATS_EN is defined.
module tb_bram_port_arbiter;

   localparam logic [31:0] WD0 = 32'h0BAD_F00D;
   localparam logic [31:0] WD1 = 32'h5EED_CAFE;
   localparam logic [3:0]  BE0 = 4'hF;
   localparam logic [3:0]  BE1 = 4'h3;

   logic        clk25 = 1'b0;
   logic        fpga_rst_n;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [12:0] r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;
   logic [3:0]  r0_be, r1_be;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic        bram_ce, bram_we;
   logic [12:0] bram_addr;
   logic [31:0] bram_wdata, bram_rdata;
   logic [3:0]  bram_webyte;
`ifdef BRAM_ARB_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   int checks   = 0;
   int failures = 0;

   always #20 clk25 = ~clk25;

   bram_port_arbiter dut (
      .clk25       (clk25),
      .fpga_rst_n  (fpga_rst_n),
      .r0_req      (r0_req),
      .r0_we       (r0_we),
      .r0_addr     (r0_addr),
      .r0_wdata    (r0_wdata),
      .r0_be       (r0_be),
      .r0_gnt      (r0_gnt),
      .r0_rvalid   (r0_rvalid),
      .r0_rdata    (r0_rdata),
      .r1_req      (r1_req),
      .r1_we       (r1_we),
      .r1_addr     (r1_addr),
      .r1_wdata    (r1_wdata),
      .r1_be       (r1_be),
      .r1_gnt      (r1_gnt),
      .r1_rvalid   (r1_rvalid),
      .r1_rdata    (r1_rdata),
      .bram_ce     (bram_ce),
      .bram_we     (bram_we),
      .bram_addr   (bram_addr),
      .bram_wdata  (bram_wdata),
      .bram_webyte (bram_webyte),
      .bram_rdata  (bram_rdata)
`ifdef BRAM_ARB_STATS_EN
      ,
      .stat_clr      (stat_clr),
      .stat_gnt0     (stat_gnt0),
      .stat_gnt1     (stat_gnt1),
      .stat_conflict (stat_conflict)
`endif
   );

   // BRAM model: 8K x 32, byte writes, output register (data two cycles after the command).
   logic [31:0] mem [0:8191];
   logic [31:0] rd_s1, rd_s2;

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 32'hA500_0000 | 32'(i);
      rd_s1 = '0;
      rd_s2 = '0;
   end

   always @(posedge clk25) begin
      if (bram_ce) begin
         if (bram_we)
            for (int b = 0; b < 4; b++)
               if (bram_webyte[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
         rd_s1 <= mem[bram_addr];
      end
      rd_s2 <= rd_s1;
   end

   assign bram_rdata = rd_s2;

   typedef struct {
      logic        req0, req1, we0, we1;
      logic [12:0] addr0, addr1;
      logic        g0, g1, rv0, rv1;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(input bit q0, q1, w0, w1, input int a0, a1,
                               input bit g0, g1, v0, v1, input logic [31:0] d);
      vec_t v;
      v.req0 = q0;  v.req1 = q1;  v.we0 = w0;  v.we1 = w1;
      v.addr0 = 13'(a0);  v.addr1 = 13'(a1);
      v.g0 = g0;  v.g1 = g1;  v.rv0 = v0;  v.rv1 = v1;  v.rdata = d;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk25);
      #1;
   endtask

   task automatic drive(input int id, input logic req, input logic we, input logic [12:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (id == 0) begin
         r0_req = req;  r0_we = we;  r0_addr = addr;  r0_wdata = wdata;  r0_be = be;
      end else begin
         r1_req = req;  r1_we = we;  r1_addr = addr;  r1_wdata = wdata;  r1_be = be;
      end
   endtask

   task automatic idle();
      r0_req = 1'b0;
      r1_req = 1'b0;
   endtask

   task automatic write_cmd(input int id, input logic [12:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
      drive(id, 1'b1, 1'b1, addr, data, be);
      #1;
      check($sformatf("wr_gnt_r%0d_%h", id, addr), (id == 0) ? r0_gnt : r1_gnt, 1);
      cycle();
      drive(id, 1'b0, 1'b0, addr, data, be);
   endtask

   // Read granted in t: rvalid must be low in t+2, high in t+3 with data, low again in t+4.
   task automatic read_check(input int id, input logic [12:0] addr, input logic [31:0] exp);
      drive(id, 1'b1, 1'b0, addr, 32'h0, 4'h0);
      #1;
      check($sformatf("rd_gnt_r%0d_%h", id, addr), (id == 0) ? r0_gnt : r1_gnt, 1);
      cycle();
      drive(id, 1'b0, 1'b0, addr, 32'h0, 4'h0);
      cycle();
      check($sformatf("rd_early_r%0d_%h", id, addr), (id == 0) ? r0_rvalid : r1_rvalid, 0);
      cycle();
      check($sformatf("rd_rvalid_r%0d_%h", id, addr), (id == 0) ? r0_rvalid : r1_rvalid, 1);
      check($sformatf("rd_other_r%0d_%h", id, addr), (id == 0) ? r1_rvalid : r0_rvalid, 0);
      check($sformatf("rd_data_r%0d_%h", id, addr), (id == 0) ? r0_rdata : r1_rdata, exp);
      cycle();
      check($sformatf("rd_late_r%0d_%h", id, addr), (id == 0) ? r0_rvalid : r1_rvalid, 0);
   endtask

   initial begin
      vec_t        vecs [16];
      vec_t        v;
      logic        ew;
      logic [12:0] ea;
      logic [31:0] ed;
      logic [3:0]  eb;

      // Both requesting from reset alternate r0,r1,...; reads return three cycles after grant.
      vecs[0]  = mk(1, 1, 0, 0, 'h0001, 'h0002, 1, 0, 0, 0, 32'h0);
      vecs[1]  = mk(1, 1, 0, 0, 'h0003, 'h0002, 0, 1, 0, 0, 32'h0);
      vecs[2]  = mk(1, 1, 0, 0, 'h0003, 'h0004, 1, 0, 0, 0, 32'h0);
      vecs[3]  = mk(1, 1, 0, 0, 'h0005, 'h0004, 0, 1, 1, 0, 32'hA500_0001);
      vecs[4]  = mk(1, 1, 0, 0, 'h0005, 'h0006, 1, 0, 0, 1, 32'hA500_0002);
      vecs[5]  = mk(1, 1, 0, 0, 'h0007, 'h0006, 0, 1, 1, 0, 32'hA500_0003);
      vecs[6]  = mk(0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 0, 1, 32'hA500_0004);
      vecs[7]  = mk(0, 1, 0, 0, 'h0000, 'h0007, 0, 1, 1, 0, 32'hA500_0005);
      vecs[8]  = mk(1, 0, 1, 0, 'h0030, 'h0000, 1, 0, 0, 1, 32'hA500_0006);
      vecs[9]  = mk(1, 1, 1, 1, 'h0031, 'h0032, 0, 1, 0, 0, 32'h0);
      vecs[10] = mk(0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 0, 1, 32'hA500_0007);
      vecs[11] = mk(1, 1, 0, 1, 'h0008, 'h0033, 1, 0, 0, 0, 32'h0);
      vecs[12] = mk(0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 0, 0, 32'h0);
      vecs[13] = mk(0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 0, 0, 32'h0);
      vecs[14] = mk(0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 1, 0, 32'hA500_0008);
      vecs[15] = mk(0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 0, 0, 32'h0);

      fpga_rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
`ifdef BRAM_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (3) cycle();
      check("rst_bram_ce", bram_ce, 0);
      check("rst_bram_we", bram_we, 0);
      check("rst_bram_webyte", bram_webyte, 0);
      check("rst_bram_addr", bram_addr, 0);
      check("rst_bram_wdata", bram_wdata, 0);
      check("rst_r0_rvalid", r0_rvalid, 0);
      check("rst_r1_rvalid", r1_rvalid, 0);
      fpga_rst_n = 1'b1;
      cycle();

      for (int i = 0; i < 16; i++) begin
         v = vecs[i];
         drive(0, v.req0, v.we0, v.addr0, WD0, BE0);
         drive(1, v.req1, v.we1, v.addr1, WD1, BE1);
         #1;
         check($sformatf("v%0d_gnt0", i), r0_gnt, v.g0);
         check($sformatf("v%0d_gnt1", i), r1_gnt, v.g1);
         check($sformatf("v%0d_rvalid0", i), r0_rvalid, v.rv0);
         check($sformatf("v%0d_rvalid1", i), r1_rvalid, v.rv1);
         if (v.rv0 || v.rv1)
            check($sformatf("v%0d_rdata", i), v.rv0 ? r0_rdata : r1_rdata, v.rdata);
         ew = (v.g0 || v.g1) && (v.g1 ? v.we1 : v.we0);
         ea = v.g1 ? v.addr1 : v.addr0;
         ed = v.g1 ? WD1 : WD0;
         eb = ew ? (v.g1 ? BE1 : BE0) : 4'h0;
         cycle();
         check($sformatf("v%0d_bram_ce", i), bram_ce, v.g0 | v.g1);
         check($sformatf("v%0d_bram_we", i), bram_we, ew);
         check($sformatf("v%0d_bram_webyte", i), bram_webyte, eb);
         if (v.g0 || v.g1) begin
            check($sformatf("v%0d_bram_addr", i), bram_addr, ea);
            check($sformatf("v%0d_bram_wdata", i), bram_wdata, ed);
         end
      end
      idle();
      cycle();

      // Write then read back-to-back from r0: new data returns.
      write_cmd(0, 13'h0010, 32'hDEAD_BEEF, 4'hF);
      read_check(0, 13'h0010, 32'hDEAD_BEEF);

      // Byte write at the top address; address 0 must be untouched.
      write_cmd(0, 13'h1FFF, 32'h1122_3344, 4'hF);
      write_cmd(0, 13'h1FFF, 32'hAABB_CCDD, 4'b0101);
      read_check(1, 13'h1FFF, 32'h11BB_33DD);
      read_check(0, 13'h0000, 32'hA500_0000);

      // Zero byte-enable write is issued but changes nothing.
      write_cmd(1, 13'h0020, 32'h1234_5678, 4'hF);
      drive(1, 1'b1, 1'b1, 13'h0020, 32'hFFFF_FFFF, 4'h0);
      #1;
      check("zbe_gnt", r1_gnt, 1);
      cycle();
      idle();
      check("zbe_bram_ce", bram_ce, 1);
      check("zbe_bram_we", bram_we, 1);
      check("zbe_bram_webyte", bram_webyte, 0);
      cycle();
      read_check(1, 13'h0020, 32'h1234_5678);

      // r1 read in flight when reset hits one cycle later.
      drive(1, 1'b1, 1'b0, 13'h0004, 32'h0, 4'h0);
      #1;
      check("mid_gnt1", r1_gnt, 1);
      cycle();
      idle();
      fpga_rst_n = 1'b0;
      #1;
      check("mid_rst_bram_ce", bram_ce, 0);
      check("mid_rst_bram_addr", bram_addr, 0);
      check("mid_rst_bram_wdata", bram_wdata, 0);
      check("mid_rst_bram_we", bram_we, 0);
      check("mid_rst_bram_webyte", bram_webyte, 0);
      cycle();
      fpga_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("mid_no_rvalid1_%0d", i), r1_rvalid, 0);
         check($sformatf("mid_no_rvalid0_%0d", i), r0_rvalid, 0);
         cycle();
      end

      // Leave priority pointing at r1, then reset: r0 must win the next contention.
      write_cmd(0, 13'h0040, 32'h0, 4'h0);
      fpga_rst_n = 1'b0;
      cycle();
      fpga_rst_n = 1'b1;
      cycle();
      drive(0, 1'b1, 1'b0, 13'h0001, 32'h0, 4'h0);
      drive(1, 1'b1, 1'b0, 13'h0002, 32'h0, 4'h0);
      #1;
      check("post_rst_gnt0", r0_gnt, 1);
      check("post_rst_gnt1", r1_gnt, 0);
      cycle();
      idle();
      repeat (4) cycle();

`ifdef BRAM_ARB_STATS_EN
      stat_clr = 1'b1;
      cycle();
      stat_clr = 1'b0;
      check("stat_clr_gnt0", stat_gnt0, 0);
      for (int i = 0; i < 10; i++) begin
         drive(0, 1'b1, 1'b0, 13'(i), 32'h0, 4'h0);
         drive(1, 1'b1, 1'b0, 13'(i), 32'h0, 4'h0);
         cycle();
      end
      idle();
      check("stat_conflict", stat_conflict, 10);
      check("stat_gnt0", stat_gnt0, 5);
      check("stat_gnt1", stat_gnt1, 5);
      stat_clr = 1'b1;
      drive(0, 1'b1, 1'b0, 13'h0, 32'h0, 4'h0);
      drive(1, 1'b1, 1'b0, 13'h0, 32'h0, 4'h0);
      cycle();
      stat_clr = 1'b0;
      idle();
      check("stat_clr2_conflict", stat_conflict, 0);
      check("stat_clr2_gnt0", stat_gnt0, 0);
      check("stat_clr2_gnt1", stat_gnt1, 0);
      repeat (4) cycle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
